// File: rtl/order_pkg.sv
// Shared order-stream definitions: header codes, field widths and the encoder FSM states.
package order_pkg;

    localparam int unsigned ORDER_ADDR_W = 8;
    localparam int unsigned ORDER_LEN_W  = 16;

    localparam logic [7:0] ORDER_HDR_WRITE = 8'h57;
    localparam logic [7:0] ORDER_HDR_READ  = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_PAYLOAD,
        ST_RSP_WAIT
    } order_state_t;

endpackage

// File: rtl/order_encoder.sv
// Serializes register transactions into HDR/ADDR/LEN_HI/LEN_LO/payload orders and collects read responses.
// Optional response timeout: define ORDER_ENCODER_TIMEOUT_EN.
module order_encoder
    import order_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic                    clk,
    input  logic                    res_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ORDER_ADDR_W-1:0] cmd_address,
    input  logic [ORDER_LEN_W-1:0]  cmd_length,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [7:0]              wd_data,
    output logic [7:0]              wo_data,
    output logic                    wo_wr,
    input  logic                    wo_full,
    input  logic [7:0]              ri_data,
    input  logic                    ri_empty,
    output logic                    ri_read,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [7:0]              rsp_data,
    output logic                    rsp_last,
    output logic                    busy,
    output logic                    err_timeout
);

    order_state_t            state;
    logic                    is_write;
    logic [ORDER_ADDR_W-1:0] addr;
    logic [ORDER_LEN_W-1:0]  count;
    logic                    tmo_expire;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Byte-level handshakes are combinational from state and the live FIFO flags.
    always_comb begin
        wo_wr     = 1'b0;
        wo_data   = 8'h00;
        wd_ready  = 1'b0;
        ri_read   = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
        rsp_last  = 1'b0;
        case (state)
            ST_HDR: begin
                wo_wr   = !wo_full;
                wo_data = is_write ? ORDER_HDR_WRITE : ORDER_HDR_READ;
            end
            ST_ADDR: begin
                wo_wr   = !wo_full;
                wo_data = addr;
            end
            ST_LEN_HI: begin
                wo_wr   = !wo_full;
                wo_data = count[15:8];
            end
            ST_LEN_LO: begin
                wo_wr   = !wo_full;
                wo_data = count[7:0];
            end
            ST_PAYLOAD: begin
                wo_wr    = wd_valid && !wo_full;
                wd_ready = wd_valid && !wo_full;
                wo_data  = wd_data;
            end
            ST_RSP_WAIT: begin
                rsp_valid = !ri_empty;
                rsp_data  = ri_data;
                ri_read   = !ri_empty && rsp_ready;
                rsp_last  = !ri_empty && (count == ORDER_LEN_W'(1));
            end
            default: ;
        endcase
    end

    // Order sequencing; count holds the length in the header and then counts bytes down.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state    <= ST_IDLE;
            is_write <= 1'b0;
            addr     <= '0;
            count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        is_write <= cmd_write;
                        addr     <= cmd_address;
                        count    <= cmd_length;
                        state    <= ST_HDR;
                    end
                end
                ST_HDR:    if (wo_wr) state <= ST_ADDR;
                ST_ADDR:   if (wo_wr) state <= ST_LEN_HI;
                ST_LEN_HI: if (wo_wr) state <= ST_LEN_LO;
                ST_LEN_LO: begin
                    if (wo_wr) begin
                        if (count == '0)  state <= ST_IDLE;
                        else if (is_write) state <= ST_PAYLOAD;
                        else               state <= ST_RSP_WAIT;
                    end
                end
                ST_PAYLOAD: begin
                    if (wo_wr) begin
                        count <= count - ORDER_LEN_W'(1);
                        if (count == ORDER_LEN_W'(1)) state <= ST_IDLE;
                    end
                end
                ST_RSP_WAIT: begin
                    if (ri_read) begin
                        count <= count - ORDER_LEN_W'(1);
                        if (count == ORDER_LEN_W'(1)) state <= ST_IDLE;
                    end else if (tmo_expire) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ORDER_ENCODER_TIMEOUT_EN
    logic [23:0] tmo_cnt;
    logic        err_q;

    assign tmo_expire  = (state == ST_RSP_WAIT) && !ri_read && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
    assign err_timeout = err_q;

    // Idle-response counter restarts on every pop and whenever the FSM is outside RSP_WAIT.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && cmd_valid) err_q <= 1'b0;
            else if (tmo_expire)               err_q <= 1'b1;

            if (state != ST_RSP_WAIT || ri_read) tmo_cnt <= '0;
            else if (!tmo_expire)                tmo_cnt <= tmo_cnt + 24'd1;
        end
    end
`else
    assign tmo_expire  = 1'b0;
    // Parameter kept referenced so both builds expose the same interface.
    assign err_timeout = 1'b0 & (TIMEOUT_CYCLES != 24'd0);
`endif

endmodule
